alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined successor to the core's combinational ALU. Operands are accepted with a valid/ready handshake and pass through `STAGES` register stages, with full backpressure and flush. The block adds three-operand SHA-256 primitives (Σ0, Σ1, Ch, Maj, ADD3) alongside the integer, shift, rotate and branch ops. It sits between decode/register-read and writeback in the miner core.

## Interface
- `WIDTH`, 32: datapath width; legal values are 32 and 64.
- `STAGES`, 2: number of pipeline register stages; legal values are 1–4.
- `TAG_W`, 5: width of the sideband tag (destination register index).
- `clk`  in  1  clock.
- `n_reset`  in  1  reset, synchronous, active-low.
- `valid_i`  in  1  input beat valid.
- `ready_o`  out  1  block can accept an input beat.
- `op_i`  in  `alu_op_e` (5)  operation.
- `a_i`, `b_i`, `c_i`  in  `WIDTH`  operands; `a` corresponds to the old `rd`, `b` to the old `rs`.
- `tag_i`  in  `TAG_W`  sideband tag, carried unchanged.
- `flush_i`  in  1  kill all in-flight beats.
- `valid_o`  out  1  output beat valid.
- `ready_i`  in  1  downstream accepts the output beat.
- `result_o`  out  `WIDTH`  result.
- `branch_taken_o`  out  1  branch condition.
- `tag_o`  out  `TAG_W`  tag of the output beat.
- `illegal_o`  out  1  the output beat carried an undefined op, or a SHA op with `WIDTH`≠32.

## Operation
- Let `sh` = `b_i[$clog2(WIDTH)-1:0]`.
- Arithmetic and logic ops:
  - `ADD`, `SUB`, `AND`, `OR`, `XOR`, `NOR` are the usual bitwise/modular ops on `a`, `b`.
  - `ADD3` = `a+b+c` mod 2^WIDTH.
- Shifts and rotates:
  - `SLL`, `SRL` shift logically by `sh`; `SRA` shifts arithmetically by `sh`.
  - `ROL`, `ROR` rotate by `sh`. A rotate by 0 returns `a` exactly; no shift by `WIDTH` is ever performed.
- Compares: `SLT` (signed) and `SLTU` (unsigned) produce 1/0, zero-extended.
- Moves: `PASSA` → `a`; `PASSB` → `b`. These are used for loads, stores, moves and jumps.
- SHA-256 primitives, legal only when `WIDTH`=32:
  - `LSIG0(b)` = ROTR7 ^ ROTR18 ^ SHR3.
  - `LSIG1(b)` = ROTR17 ^ ROTR19 ^ SHR10.
  - `BSIG0(a)` = ROTR2 ^ ROTR13 ^ ROTR22.
  - `BSIG1(a)` = ROTR6 ^ ROTR11 ^ ROTR25.
  - `CH` = `(a&b)^(~a&c)`.
  - `MAJ` = `(a&b)^(a&c)^(b&c)`.
- Branch ops: `BEQZ`, `BNEZ`, `BGTZ`, `BLTZ` test `a` (signed where relevant). They set `branch_taken_o`; `result_o` is 0.
- Undefined op, or a SHA op with `WIDTH`=64: `result_o`=0, `branch_taken_o`=0, `illegal_o`=1.
- Compute is combinational on the input beat. The result, branch flag, illegal flag and tag are captured in stage 0, then shift through stages 1..`STAGES`-1.
- Stage k advances when `!v[k+1] || adv[k+1]`. The last stage advances when `ready_i`.
- `ready_o` = `!v[0] || adv[0]`, which is combinational from `ready_i`.

## Timing
- Reset (`n_reset`=0 at a `clk` edge) clears all stage valids and data.
  - After reset: `valid_o`=0, `result_o`=0, `branch_taken_o`=0, `tag_o`=0, `illegal_o`=0.
  - `ready_o`=1 from the first cycle after reset.
  - Reset mid-operation drops every in-flight beat; no beat emerges.
- Latency: a beat accepted at edge N is presented on `valid_o` after edge N+`STAGES`-1. It is visible in the cycle following edge N+`STAGES`-1.
- Throughput: one beat per cycle while `ready_i`=1.
- Backpressure: with `ready_i`=0, the output holds `result_o`/`tag_o` stable. The pipe fills, and `ready_o` drops once all `STAGES` slots are valid. No beat is lost or duplicated.
- Handshake: transfer occurs on `valid && ready` at a `clk` edge. `valid_o` never depends on `ready_i`.
- Flush: `flush_i`=1 at an edge clears all valids. An input beat presented in the same cycle is dropped.
- Flush and reset are independent; reset has priority.
- Output data registers are not cleared on flush; only valids are.

## Structure
- Package `definitions`:
  - Add `alu_op_e` (5-bit enum covering every op above).
  - Add `localparam`s for the SHA rotate/shift amounts.
  - Add a `sha_fn` function set so the core and tests share it.
- Sub-module `alu_compute`: purely combinational, (`op`, `a`, `b`, `c`) → (`result`, `branch`, `illegal`), parametrised by `WIDTH`.
- `alu_pipe` owns the handshake and the stage registers, generated for `STAGES`.

## Test plan
- Reset: assert `n_reset`=0 for 3 cycles with `valid_i`=1 → `valid_o`=0 and all outputs 0; `ready_o`=1 on the first cycle after release.
- SHA ops, `WIDTH`=32, `STAGES`=2:
  - `LSIG0` with `b`=0x00000001 → 0x02004000.
  - `LSIG1` with `b`=0x00000001 → 0x0000A000.
  - `CH` with `a`=0xFFFF0000, `b`=0x12345678, `c`=0x9ABCDEF0 → 0x1234DEF0.
  - Each result appears 2 cycles after acceptance.
- Rotate boundary, `a`=0x80000001:
  - `ROR` `b`=0 → 0x80000001.
  - `ROR` `b`=1 → 0xC0000000.
  - `ROL` `b`=4 → 0x00000018.
  - `ROL` `b`=32 → 0x80000001, since `sh`=0.
- Backpressure: stream 6 `ADD` beats (tags 0–5), hold `ready_i`=0 for cycles 2–7, then release → `ready_o` falls after `STAGES` beats are held, and outputs arrive in tag order 0–5 with no loss or duplicates.
- Flush and illegal:
  - Flush with 2 beats in flight plus a simultaneous input → no `valid_o` for those 3 beats.
  - Next, `MAJ` at `WIDTH`=64 → `result_o`=0, `illegal_o`=1.
- Compares/branches:
  - `SLT` with `a`=0xFFFFFFFF, `b`=1 → 1.
  - `SLTU` with the same operands → 0.
  - `BLTZ` with `a`=0x80000000 → `branch_taken_o`=1, `result_o`=0.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared ALU definitions: operation encoding and SHA-256 round primitives
// used by both the pipelined ALU and its tests.
package definitions;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_NOR   = 5'd5,
    OP_ADD3  = 5'd6,
    OP_SLL   = 5'd7,
    OP_SRL   = 5'd8,
    OP_SRA   = 5'd9,
    OP_ROL   = 5'd10,
    OP_ROR   = 5'd11,
    OP_SLT   = 5'd12,
    OP_SLTU  = 5'd13,
    OP_PASSA = 5'd14,
    OP_PASSB = 5'd15,
    OP_LSIG0 = 5'd16,
    OP_LSIG1 = 5'd17,
    OP_BSIG0 = 5'd18,
    OP_BSIG1 = 5'd19,
    OP_CH    = 5'd20,
    OP_MAJ   = 5'd21,
    OP_BEQZ  = 5'd22,
    OP_BNEZ  = 5'd23,
    OP_BGTZ  = 5'd24,
    OP_BLTZ  = 5'd25
  } alu_op_e;

  localparam int LSIG0_R1 = 7;
  localparam int LSIG0_R2 = 18;
  localparam int LSIG0_S  = 3;
  localparam int LSIG1_R1 = 17;
  localparam int LSIG1_R2 = 19;
  localparam int LSIG1_S  = 10;
  localparam int BSIG0_R1 = 2;
  localparam int BSIG0_R2 = 13;
  localparam int BSIG0_R3 = 22;
  localparam int BSIG1_R1 = 6;
  localparam int BSIG1_R2 = 11;
  localparam int BSIG1_R3 = 25;

  // Only ever called with constant, non-zero amounts, so it reduces to wiring.
  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sha_lsig0(input logic [31:0] x);
    return rotr32(x, LSIG0_R1) ^ rotr32(x, LSIG0_R2) ^ (x >> LSIG0_S);
  endfunction

  function automatic logic [31:0] sha_lsig1(input logic [31:0] x);
    return rotr32(x, LSIG1_R1) ^ rotr32(x, LSIG1_R2) ^ (x >> LSIG1_S);
  endfunction

  function automatic logic [31:0] sha_bsig0(input logic [31:0] x);
    return rotr32(x, BSIG0_R1) ^ rotr32(x, BSIG0_R2) ^ rotr32(x, BSIG0_R3);
  endfunction

  function automatic logic [31:0] sha_bsig1(input logic [31:0] x);
    return rotr32(x, BSIG1_R1) ^ rotr32(x, BSIG1_R2) ^ rotr32(x, BSIG1_R3);
  endfunction

  function automatic logic [31:0] sha_ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] sha_maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/alu_compute.sv
// Combinational ALU core: integer, shift/rotate, compare, branch and
// SHA-256 primitives on one operand beat.
module alu_compute
  import definitions::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] result,
  output logic             branch,
  output logic             illegal
);

  localparam int SHW    = $clog2(WIDTH);
  localparam bit SHA_OK = (WIDTH == 32);

  logic        [SHW-1:0]   sh;
  logic        [SHW:0]     rsh;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  assign sh  = b[SHW-1:0];
  // Complementary rotate amount; only used when sh is non-zero, so never WIDTH.
  assign rsh = (SHW+1)'(WIDTH) - {1'b0, sh};
  assign a_s = a;
  assign b_s = b;

  always_comb begin
    result  = '0;
    branch  = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOR:   result = ~(a | b);
      OP_ADD3:  result = a + b + c;
      OP_SLL:   result = a << sh;
      OP_SRL:   result = a >> sh;
      OP_SRA:   result = a_s >>> sh;
      OP_ROL:   result = (sh == '0) ? a : ((a << sh) | (a >> rsh));
      OP_ROR:   result = (sh == '0) ? a : ((a >> sh) | (a << rsh));
      OP_SLT:   result = {{(WIDTH-1){1'b0}}, a_s < b_s};
      OP_SLTU:  result = {{(WIDTH-1){1'b0}}, a < b};
      OP_PASSA: result = a;
      OP_PASSB: result = b;
      OP_LSIG0: if (SHA_OK) result = WIDTH'(sha_lsig0(b[31:0])); else illegal = 1'b1;
      OP_LSIG1: if (SHA_OK) result = WIDTH'(sha_lsig1(b[31:0])); else illegal = 1'b1;
      OP_BSIG0: if (SHA_OK) result = WIDTH'(sha_bsig0(a[31:0])); else illegal = 1'b1;
      OP_BSIG1: if (SHA_OK) result = WIDTH'(sha_bsig1(a[31:0])); else illegal = 1'b1;
      OP_CH:    if (SHA_OK) result = WIDTH'(sha_ch(a[31:0], b[31:0], c[31:0])); else illegal = 1'b1;
      OP_MAJ:   if (SHA_OK) result = WIDTH'(sha_maj(a[31:0], b[31:0], c[31:0])); else illegal = 1'b1;
      OP_BEQZ:  branch = (a == '0);
      OP_BNEZ:  branch = (a != '0);
      OP_BGTZ:  branch = !a[WIDTH-1] && (|a);
      OP_BLTZ:  branch = a[WIDTH-1];
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: valid/ready handshake, STAGES register slots with
// bubble-collapsing backpressure and flush, sideband tag carried through.
module alu_pipe
  import definitions::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             branch_taken_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);

  logic [WIDTH-1:0]  c_res;
  logic              c_br;
  logic              c_ill;

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] br_p;
  logic [STAGES-1:0] ill_p;
  logic [WIDTH-1:0]  res_p [STAGES];
  logic [TAG_W-1:0]  tag_p [STAGES];
  logic [STAGES-1:0] adv;

  alu_compute #(.WIDTH(WIDTH)) u_compute (
    .op      (op_i),
    .a       (a_i),
    .b       (b_i),
    .c       (c_i),
    .result  (c_res),
    .branch  (c_br),
    .illegal (c_ill)
  );

  // A stage may take new content when the sink accepts or any later slot
  // is empty; written out flat so there is no combinational chain through adv.
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = ready_i;
      for (int j = k + 1; j < STAGES; j++)
        if (!vld_p[j]) adv[k] = 1'b1;
    end
  end

  assign ready_o = !vld_p[0] || adv[0];

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      vld_p <= '0;
      br_p  <= '0;
      ill_p <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_p[k] <= '0;
        tag_p[k] <= '0;
      end
    end else begin
      // stage 0: capture the combinational result of the input beat
      if (ready_o) begin
        vld_p[0] <= valid_i;
        if (valid_i) begin
          res_p[0] <= c_res;
          br_p[0]  <= c_br;
          ill_p[0] <= c_ill;
          tag_p[0] <= tag_i;
        end
      end
      // stages 1..STAGES-1: shift forward when the slot frees up
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k-1]) begin
          vld_p[k] <= vld_p[k-1];
          if (vld_p[k-1]) begin
            res_p[k] <= res_p[k-1];
            br_p[k]  <= br_p[k-1];
            ill_p[k] <= ill_p[k-1];
            tag_p[k] <= tag_p[k-1];
          end
        end
      end
      if (flush_i) vld_p <= '0;
    end
  end

  assign valid_o        = vld_p[STAGES-1];
  assign result_o       = res_p[STAGES-1];
  assign branch_taken_o = br_p[STAGES-1];
  assign illegal_o      = ill_p[STAGES-1];
  assign tag_o          = tag_p[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: 32-bit/2-stage and 64-bit/3-stage instances, directed
// vector table, hand-written backpressure/flush sequences and random traffic.
module tb_alu_pipe;
  import definitions::*;

  localparam int S32 = 2;
  localparam int S64 = 3;

  logic clk = 1'b0;
  logic n_reset;

  logic        d32_v_i, d32_rdy_o, d32_flush, d32_v_o, d32_rdy_i, d32_br, d32_ill;
  alu_op_e     d32_op;
  logic [31:0] d32_a, d32_b, d32_c, d32_res;
  logic [4:0]  d32_tag, d32_tag_o;

  logic        d64_v_i, d64_rdy_o, d64_flush, d64_v_o, d64_rdy_i, d64_br, d64_ill;
  alu_op_e     d64_op;
  logic [63:0] d64_a, d64_b, d64_c, d64_res;
  logic [4:0]  d64_tag, d64_tag_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pops32 = 0;
  int pops64 = 0;

  alu_pipe #(.WIDTH(32), .STAGES(S32), .TAG_W(5)) u32 (
    .clk(clk), .n_reset(n_reset), .valid_i(d32_v_i), .ready_o(d32_rdy_o),
    .op_i(d32_op), .a_i(d32_a), .b_i(d32_b), .c_i(d32_c), .tag_i(d32_tag),
    .flush_i(d32_flush), .valid_o(d32_v_o), .ready_i(d32_rdy_i),
    .result_o(d32_res), .branch_taken_o(d32_br), .tag_o(d32_tag_o),
    .illegal_o(d32_ill)
  );

  alu_pipe #(.WIDTH(64), .STAGES(S64), .TAG_W(5)) u64 (
    .clk(clk), .n_reset(n_reset), .valid_i(d64_v_i), .ready_o(d64_rdy_o),
    .op_i(d64_op), .a_i(d64_a), .b_i(d64_b), .c_i(d64_c), .tag_i(d64_tag),
    .flush_i(d64_flush), .valid_o(d64_v_o), .ready_i(d64_rdy_i),
    .result_o(d64_res), .branch_taken_o(d64_br), .tag_o(d64_tag_o),
    .illegal_o(d64_ill)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic        br;
    logic        ill;
    logic [4:0]  tag;
    int          acc;
  } exp_t;

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] res;
    logic        br;
    logic        ill;
  } vec_t;

  exp_t q32[$];
  exp_t q64[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rr32(input logic [63:0] x, input int n);
    return ((x >> n) | (x << (32 - n))) & 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Reference: results straight from the operation definitions, plain arithmetic on 64 bits.
  function automatic exp_t model(input alu_op_e op, input logic [63:0] a_in, b_in, c_in, input int w);
    logic [63:0] m, a, b, c, r;
    logic signed [63:0] sa, sb;
    int sh;
    exp_t e;
    m  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    a  = a_in & m;
    b  = b_in & m;
    c  = c_in & m;
    sa = (w == 32) ? {{32{a[31]}}, a[31:0]} : a;
    sb = (w == 32) ? {{32{b[31]}}, b[31:0]} : b;
    sh = int'(b % 64'(w));
    r = '0;
    e.br = 1'b0;
    e.ill = 1'b0;
    e.tag = '0;
    e.acc = 0;
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOR:   r = ~(a | b);
      OP_ADD3:  r = a + b + c;
      OP_SLL:   r = a << sh;
      OP_SRL:   r = a >> sh;
      OP_SRA:   r = sa >>> sh;
      OP_ROL:   r = (a << sh) | (a >> (w - sh));
      OP_ROR:   r = (a >> sh) | (a << (w - sh));
      OP_SLT:   r = (sa < sb) ? 64'd1 : 64'd0;
      OP_SLTU:  r = (a < b) ? 64'd1 : 64'd0;
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      OP_LSIG0: if (w != 32) e.ill = 1'b1; else r = rr32(b, 7) ^ rr32(b, 18) ^ (b >> 3);
      OP_LSIG1: if (w != 32) e.ill = 1'b1; else r = rr32(b, 17) ^ rr32(b, 19) ^ (b >> 10);
      OP_BSIG0: if (w != 32) e.ill = 1'b1; else r = rr32(a, 2) ^ rr32(a, 13) ^ rr32(a, 22);
      OP_BSIG1: if (w != 32) e.ill = 1'b1; else r = rr32(a, 6) ^ rr32(a, 11) ^ rr32(a, 25);
      OP_CH:    if (w != 32) e.ill = 1'b1; else r = (a & b) ^ (~a & c);
      OP_MAJ:   if (w != 32) e.ill = 1'b1; else r = (a & b) ^ (a & c) ^ (b & c);
      OP_BEQZ:  e.br = (a == 0);
      OP_BNEZ:  e.br = (a != 0);
      OP_BGTZ:  e.br = (sa > 0);
      OP_BLTZ:  e.br = (sa < 0);
      default:  e.ill = 1'b1;
    endcase
    e.res = r & m;
    return e;
  endfunction

  // Scoreboard for the 32-bit pipe, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    bit ev, er;
    if (!n_reset) q32.delete();
    else begin
      er = (q32.size() < S32) || d32_rdy_i;
      check("ready32", d32_rdy_o, er);
      ev = (q32.size() > 0) && (cyc >= q32[0].acc + S32 - 1);
      check("valid32", d32_v_o, ev);
      if (ev) begin
        check("res32", {32'b0, d32_res}, q32[0].res);
        check("br32", d32_br, q32[0].br);
        check("ill32", d32_ill, q32[0].ill);
        check("tag32", d32_tag_o, q32[0].tag);
      end
      if (d32_flush) q32.delete();
      else begin
        if (ev && d32_rdy_i) begin
          void'(q32.pop_front());
          pops32++;
        end
        if (d32_v_i && er) begin
          e = model(d32_op, {32'b0, d32_a}, {32'b0, d32_b}, {32'b0, d32_c}, 32);
          e.tag = d32_tag;
          e.acc = cyc + 1;
          q32.push_back(e);
        end
      end
    end
  end

  // Scoreboard for the 64-bit pipe.
  always @(negedge clk) begin
    exp_t e;
    bit ev, er;
    if (!n_reset) q64.delete();
    else begin
      er = (q64.size() < S64) || d64_rdy_i;
      check("ready64", d64_rdy_o, er);
      ev = (q64.size() > 0) && (cyc >= q64[0].acc + S64 - 1);
      check("valid64", d64_v_o, ev);
      if (ev) begin
        check("res64", d64_res, q64[0].res);
        check("br64", d64_br, q64[0].br);
        check("ill64", d64_ill, q64[0].ill);
        check("tag64", d64_tag_o, q64[0].tag);
      end
      if (d64_flush) q64.delete();
      else begin
        if (ev && d64_rdy_i) begin
          void'(q64.pop_front());
          pops64++;
        end
        if (d64_v_i && er) begin
          e = model(d64_op, d64_a, d64_b, d64_c, 64);
          e.tag = d64_tag;
          e.acc = cyc + 1;
          q64.push_back(e);
        end
      end
    end
  end

  // Send one beat into the chosen pipe and wait (bounded) for it to emerge.
  task automatic run_beat(input bit w64, input alu_op_e op, input logic [63:0] a, b, c,
                          input logic [4:0] tag, output logic [63:0] res,
                          output logic br, ill, output logic [4:0] tag_out, output int lat);
    if (w64) begin
      d64_v_i = 1'b1; d64_op = op; d64_a = a; d64_b = b; d64_c = c; d64_tag = tag;
    end else begin
      d32_v_i = 1'b1; d32_op = op; d32_a = a[31:0]; d32_b = b[31:0]; d32_c = c[31:0]; d32_tag = tag;
    end
    @(posedge clk); #1;
    d32_v_i = 1'b0;
    d64_v_i = 1'b0;
    lat = 0;
    while (!(w64 ? d64_v_o : d32_v_o) && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res     = w64 ? d64_res : {32'b0, d32_res};
    br      = w64 ? d64_br : d32_br;
    ill     = w64 ? d64_ill : d32_ill;
    tag_out = w64 ? d64_tag_o : d32_tag_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [14];
    logic [63:0] res;
    logic        br, ill;
    logic [4:0]  tg;
    int          lat, sent, p0;
    bit          saw_low, acc;

    tbl[0]  = '{OP_LSIG0, 32'h0,        32'h00000001, 32'h0,        32'h02004000, 1'b0, 1'b0};
    tbl[1]  = '{OP_LSIG1, 32'h0,        32'h00000001, 32'h0,        32'h0000A000, 1'b0, 1'b0};
    tbl[2]  = '{OP_CH,    32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0, 32'h1234DEF0, 1'b0, 1'b0};
    tbl[3]  = '{OP_ROR,   32'h80000001, 32'd0,        32'h0,        32'h80000001, 1'b0, 1'b0};
    tbl[4]  = '{OP_ROR,   32'h80000001, 32'd1,        32'h0,        32'hC0000000, 1'b0, 1'b0};
    tbl[5]  = '{OP_ROL,   32'h80000001, 32'd4,        32'h0,        32'h00000018, 1'b0, 1'b0};
    tbl[6]  = '{OP_ROL,   32'h80000001, 32'd32,       32'h0,        32'h80000001, 1'b0, 1'b0};
    tbl[7]  = '{OP_SLT,   32'hFFFFFFFF, 32'd1,        32'h0,        32'h00000001, 1'b0, 1'b0};
    tbl[8]  = '{OP_SLTU,  32'hFFFFFFFF, 32'd1,        32'h0,        32'h00000000, 1'b0, 1'b0};
    tbl[9]  = '{OP_BLTZ,  32'h80000000, 32'h5,        32'h0,        32'h00000000, 1'b1, 1'b0};
    tbl[10] = '{OP_ADD3,  32'hFFFFFFFF, 32'd2,        32'd3,        32'h00000004, 1'b0, 1'b0};
    tbl[11] = '{alu_op_e'(5'd31), 32'h1234, 32'h5678, 32'h9,        32'h00000000, 1'b0, 1'b1};
    tbl[12] = '{OP_MAJ,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hF000F000, 1'b0, 1'b0};
    tbl[13] = '{OP_BSIG0, 32'h00000001, 32'h0,        32'h0,        32'h40080400, 1'b0, 1'b0};

    n_reset   = 1'b0;
    d32_v_i   = 1'b1; d32_op = OP_ADD; d32_a = $urandom; d32_b = $urandom; d32_c = 32'h0;
    d32_tag   = 5'd7; d32_flush = 1'b0; d32_rdy_i = 1'b1;
    d64_v_i   = 1'b1; d64_op = OP_SUB; d64_a = {$urandom, $urandom}; d64_b = 64'h1; d64_c = 64'h0;
    d64_tag   = 5'd9; d64_flush = 1'b0; d64_rdy_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid32", d32_v_o, 0);
    check("rst_res32", d32_res, 0);
    check("rst_br32", d32_br, 0);
    check("rst_tag32", d32_tag_o, 0);
    check("rst_ill32", d32_ill, 0);
    check("rst_valid64", d64_v_o, 0);
    check("rst_res64", d64_res, 0);
    check("rst_br64", d64_br, 0);
    check("rst_tag64", d64_tag_o, 0);
    check("rst_ill64", d64_ill, 0);
    n_reset = 1'b1;
    d32_v_i = 1'b0;
    d64_v_i = 1'b0;
    #1;
    check("rst_ready32", d32_rdy_o, 1);
    check("rst_ready64", d64_rdy_o, 1);

    for (int i = 0; i < 14; i++) begin
      run_beat(1'b0, tbl[i].op, {32'b0, tbl[i].a}, {32'b0, tbl[i].b}, {32'b0, tbl[i].c},
               5'(i), res, br, ill, tg, lat);
      check($sformatf("vec%0d_res", i), res, {32'b0, tbl[i].res});
      check($sformatf("vec%0d_br", i), br, tbl[i].br);
      check($sformatf("vec%0d_ill", i), ill, tbl[i].ill);
      check($sformatf("vec%0d_tag", i), tg, 5'(i));
      check($sformatf("vec%0d_latency", i), lat, S32 - 1);
    end

    run_beat(1'b1, OP_MAJ, {$urandom, $urandom}, {$urandom, $urandom}, 64'hFFFF_0000_FFFF_0000,
             5'd20, res, br, ill, tg, lat);
    check("maj64_res", res, 64'h0);
    check("maj64_ill", ill, 1);
    check("maj64_latency", lat, S64 - 1);
    run_beat(1'b1, OP_SRA, 64'h8000_0000_0000_0000, 64'd63, 64'h0, 5'd21, res, br, ill, tg, lat);
    check("sra64_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sra64_ill", ill, 0);
    @(posedge clk); #1;

    // Backpressure: six ADD beats with the sink stalled in cycles 2..7.
    p0 = pops32;
    sent = 0;
    saw_low = 1'b0;
    for (int cy = 0; cy < 40; cy++) begin
      d32_rdy_i = !(cy >= 2 && cy <= 7);
      d32_v_i   = (sent < 6);
      d32_op    = OP_ADD;
      d32_a     = $urandom;
      d32_b     = $urandom;
      d32_tag   = 5'(sent);
      #1;
      if (!d32_rdy_o) saw_low = 1'b1;
      acc = d32_v_i && d32_rdy_o;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    d32_v_i = 1'b0;
    check("bp_ready_fell", saw_low, 1);
    check("bp_sent", sent, 6);
    check("bp_delivered", pops32 - p0, 6);

    // Flush with two beats held and a third presented alongside the flush.
    p0 = pops32;
    d32_rdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d32_v_i   = 1'b1;
      d32_op    = OP_ADD;
      d32_tag   = 5'(10 + k);
      d32_flush = (k == 2);
      @(posedge clk); #1;
    end
    d32_v_i   = 1'b0;
    d32_flush = 1'b0;
    d32_rdy_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("flush_valid", d32_v_o, 0);
      @(posedge clk); #1;
    end
    check("flush_delivered", pops32 - p0, 0);

    // Random traffic on both pipes, with one reset mid-stream.
    for (int i = 0; i < 400; i++) begin
      n_reset   = !(i == 150 || i == 151);
      d32_v_i   = ($urandom_range(0, 3) != 0);
      d32_op    = alu_op_e'(5'($urandom_range(0, 31)));
      d32_a     = $urandom;
      d32_b     = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 40);
      d32_c     = $urandom;
      d32_tag   = 5'($urandom);
      d32_rdy_i = ($urandom_range(0, 3) != 0);
      d32_flush = ($urandom_range(0, 24) == 0);
      d64_v_i   = ($urandom_range(0, 3) != 0);
      d64_op    = alu_op_e'(5'($urandom_range(0, 31)));
      d64_a     = {$urandom, $urandom};
      d64_b     = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
      d64_c     = {$urandom, $urandom};
      d64_tag   = 5'($urandom);
      d64_rdy_i = ($urandom_range(0, 3) != 0);
      d64_flush = ($urandom_range(0, 24) == 0);
      @(posedge clk); #1;
    end

    n_reset   = 1'b1;
    d32_v_i   = 1'b0; d32_flush = 1'b0; d32_rdy_i = 1'b1;
    d64_v_i   = 1'b0; d64_flush = 1'b0; d64_rdy_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("drain_valid32", d32_v_o, 0);
    check("drain_valid64", d64_v_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
